reg_scoreboard: RTL



---
 rtl/reg_scoreboard.sv | 123 ++++++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters and RAW/WAW issue stall.
// Also sequences a drain: issue is held until every pending write has retired.
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic [ADDR_W-1:0]       issue_src1,
  input  logic [ADDR_W-1:0]       issue_src2,
  input  logic [ADDR_W-1:0]       issue_dest,
  input  logic                    issue_writes,
  output logic                    issue_ready,
  input  logic                    wb_valid,
  input  logic [ADDR_W-1:0]       wb_dest,
  input  logic                    flush,
  input  logic                    drain_req,
  output logic                    drain_done,
  output logic [NUM_REGS-1:0]     busy_mask,
  output logic [ADDR_W+CNT_W-1:0] outstanding,
  output logic                    wb_err
);

  localparam int OUT_W = ADDR_W + CNT_W;
  localparam logic [CNT_W-1:0] MAX_PEND = '1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t                             r_state;
  logic                               r_drain_done;
  logic                               r_wb_err;
  logic [NUM_REGS-1:0][CNT_W-1:0]     w_pend;
  logic [OUT_W-1:0]                   w_sum;
  logic                               w_haz;
  logic                               w_accept;
  logic                               w_wb_orphan;

  // Register 0 is hardwired zero, so its counter is a constant rather than state.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_pend[gi] = '0;
      end else begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        logic             w_inc;
        logic             w_dec;

        assign w_inc = w_accept && issue_writes && (issue_dest == ADDR_W'(gi));
        assign w_dec = wb_valid && (wb_dest == ADDR_W'(gi)) && (r_cnt != '0);

        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            r_cnt <= '0;
          end else if (flush) begin
            r_cnt <= '0;
          end else if (w_inc && !w_dec) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (w_dec && !w_inc) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        assign w_pend[gi] = r_cnt;
      end
      assign busy_mask[gi] = |w_pend[gi];
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_sum = w_sum + OUT_W'(w_pend[i]);
    end
  end

  // Hazards look only at registered counters; a same-cycle writeback never bypasses.
  assign w_haz = ((issue_src1 != '0) && (w_pend[issue_src1] != '0)) ||
                 ((issue_src2 != '0) && (w_pend[issue_src2] != '0)) ||
                 (issue_writes && (issue_dest != '0) && (w_pend[issue_dest] == MAX_PEND));

  assign w_accept    = issue_valid && (r_state == ST_RUN) && !w_haz && !flush;
  assign w_wb_orphan = wb_valid && (wb_dest != '0) && (w_pend[wb_dest] == '0) && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_RUN;
      r_drain_done <= 1'b0;
      r_wb_err     <= 1'b0;
    end else begin
      r_drain_done <= 1'b0;
      if (w_wb_orphan) begin
        r_wb_err <= 1'b1;
      end
      case (r_state)
        ST_RUN: begin
          if (flush || (drain_req && (w_sum == '0))) begin
            r_state      <= ST_DONE;
            r_drain_done <= 1'b1;
          end else if (drain_req) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (flush || (w_sum == '0)) begin
            r_state      <= ST_DONE;
            r_drain_done <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign issue_ready = w_accept;
  assign drain_done  = r_drain_done;
  assign outstanding = w_sum;
  assign wb_err      = r_wb_err;

endmodule
